// File: rtl/mm_data_access.sv
// Memory-stage data access unit: issues one SRAM-like bus transaction per load/store
// and returns aligned, extended load data. Optional alignment check: MM_ALE_CHECK_EN.
module mm_data_access #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_re,
  input  logic              in_we,
  input  logic [1:0]        in_size,
  input  logic              in_sign,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  input  logic              flush,
  output logic              stall,
  output logic              ld_valid,
  output logic [31:0]       ld_data,
  output logic              ale,
  output logic [ADDR_W-1:0] ale_vaddr,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [3:0]        data_sram_wstrb,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [31:0]       data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata
);
  // state | meaning
  // IDLE  | no transaction outstanding, may accept
  // REQ   | request on the bus, waiting for addr_ok
  // WAIT  | address accepted, waiting for data_ok
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state, state_nxt;
  logic              acc_wr, acc_sign, cancel, done;
  logic [1:0]        acc_size, size_eff;
  logic [ADDR_W-1:0] acc_addr;
  logic [3:0]        acc_wstrb, wstrb_nxt;
  logic [31:0]       acc_wdata, wdata_nxt, ld_ext;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic              accept, misaligned, issue, finish, ld_fire;

  // done blocks re-accepting the instruction MM1 still holds in the cycle after completion
  assign accept = in_valid & (in_re | in_we) & ~flush & ~done;

  always_comb begin
    size_eff  = (in_size == 2'd3) ? 2'd2 : in_size;
    wstrb_nxt = 4'b1111;
    wdata_nxt = in_wdata;
    case (size_eff)
      2'd0: begin
        wstrb_nxt = 4'b0001 << in_addr[1:0];
        wdata_nxt = {4{in_wdata[7:0]}};
      end
      2'd1: begin
        wstrb_nxt = in_addr[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{in_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!in_we) wstrb_nxt = 4'b0000;
  end

`ifdef MM_ALE_CHECK_EN
  logic ale_hit;
  assign misaligned = ((size_eff == 2'd1) & in_addr[0]) |
                      ((size_eff == 2'd2) & (in_addr[1:0] != 2'b00));
  assign ale_hit    = (state == IDLE) & accept & misaligned;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ale       <= 1'b0;
      ale_vaddr <= '0;
    end else begin
      ale <= ale_hit;
      if (ale_hit) ale_vaddr <= in_addr;
    end
  end
`else
  assign misaligned = 1'b0;
  assign ale        = 1'b0;
  assign ale_vaddr  = '0;
`endif

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    issue     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: if (accept && !misaligned) begin
        issue     = 1'b1;
        stall     = 1'b1;
        state_nxt = REQ;
      end
      REQ: begin
        stall = 1'b1;
        if (data_sram_addr_ok) begin
          if (data_sram_data_ok) begin
            finish    = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (data_sram_data_ok) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (acc_addr[1:0])
      2'd0:    lane_b = data_sram_rdata[7:0];
      2'd1:    lane_b = data_sram_rdata[15:8];
      2'd2:    lane_b = data_sram_rdata[23:16];
      default: lane_b = data_sram_rdata[31:24];
    endcase
    lane_h = acc_addr[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
    case (acc_size)
      2'd0:    ld_ext = {{24{acc_sign & lane_b[7]}}, lane_b};
      2'd1:    ld_ext = {{16{acc_sign & lane_h[15]}}, lane_h};
      default: ld_ext = data_sram_rdata;
    endcase
  end

  // a flush arriving together with data_ok also kills the load result
  assign ld_fire = finish & ~acc_wr & ~cancel & ~flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc_wr    <= 1'b0;
      acc_sign  <= 1'b0;
      acc_size  <= 2'd0;
      acc_addr  <= '0;
      acc_wstrb <= 4'b0000;
      acc_wdata <= 32'd0;
      cancel    <= 1'b0;
      done      <= 1'b0;
      ld_valid  <= 1'b0;
      ld_data   <= 32'd0;
    end else begin
      state    <= state_nxt;
      done     <= finish;
      ld_valid <= ld_fire;
      if (ld_fire) ld_data <= ld_ext;
      if (finish) cancel <= 1'b0;
      else if (state != IDLE && flush) cancel <= 1'b1;
      if (issue) begin
        acc_wr    <= in_we;
        acc_sign  <= in_sign;
        acc_size  <= size_eff;
        acc_addr  <= in_addr;
        acc_wstrb <= wstrb_nxt;
        acc_wdata <= wdata_nxt;
      end
    end
  end

  assign data_sram_req   = (state == REQ);
  assign data_sram_wr    = acc_wr;
  assign data_sram_size  = acc_size;
  assign data_sram_wstrb = acc_wstrb;
  assign data_sram_addr  = acc_addr;
  assign data_sram_wdata = acc_wdata;
endmodule

// File: tb/tb_mm_data_access.sv
// Directed bench for mm_data_access; bus responder timing is set per transaction.
module tb_mm_data_access;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 0, in_re = 0, in_we = 0, in_sign = 0, flush = 0;
  logic [1:0]  in_size = 0;
  logic [31:0] in_addr = 0, in_wdata = 0;
  logic        stall, ld_valid, ale;
  logic [31:0] ld_data, ale_vaddr;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok = 0, data_sram_data_ok = 0;
  logic [31:0] data_sram_rdata = 0;

  int n_tests = 0, n_fail = 0;
  int res_req, res_stall, res_ldv, res_ale;
  logic [31:0] res_ld, res_addr, res_wd;
  logic [3:0]  res_strb;
  logic [1:0]  res_size;
  logic        res_wr, res_unstable;

  mm_data_access #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_re(in_re), .in_we(in_we),
    .in_size(in_size), .in_sign(in_sign), .in_addr(in_addr), .in_wdata(in_wdata),
    .flush(flush), .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data),
    .ale(ale), .ale_vaddr(ale_vaddr), .data_sram_req(data_sram_req),
    .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one instruction into MM1 (held while stalled), answers the bus after
  // aok_dly REQ cycles and dok_dly cycles after addr_ok (0 = same cycle).
  task automatic do_txn(input logic re, input logic we, input logic [1:0] size,
                        input logic sign, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int aok_dly, input int dok_dly,
                        input bit flush_wait);
    int rq = 0, wc = 0, post = 0;
    bit in_wait = 0, fin = 0, first = 1;
    res_req = 0; res_stall = 0; res_ldv = 0; res_ale = 0; res_unstable = 0;
    res_ld = 0; res_addr = 0; res_wd = 0; res_strb = 0; res_size = 0; res_wr = 0;
    @(posedge clk); #1;
    in_valid = 1; in_re = re; in_we = we; in_size = size; in_sign = sign;
    in_addr = addr; in_wdata = wdata;
    for (int k = 0; k < 40 && !fin; k++) begin
      @(negedge clk);
      if (data_sram_req) begin
        res_req++;
        if (first) begin
          first = 0; res_addr = data_sram_addr; res_wd = data_sram_wdata;
          res_strb = data_sram_wstrb; res_size = data_sram_size; res_wr = data_sram_wr;
        end else if ({data_sram_addr, data_sram_wdata, data_sram_wstrb, data_sram_size,
                      data_sram_wr} !== {res_addr, res_wd, res_strb, res_size, res_wr})
          res_unstable = 1;
      end
      if (stall) res_stall++;
      if (ld_valid) begin res_ldv++; res_ld = ld_data; end
      if (ale) res_ale++;
      if (post == 3) fin = 1;
      @(posedge clk); #1;
      data_sram_addr_ok = 0; data_sram_data_ok = 0; flush = 0;
      if (post > 0) begin
        post++;
        if (post == 3) in_valid = 0;
      end else if (data_sram_req) begin
        if (rq == aok_dly) begin
          data_sram_addr_ok = 1;
          if (dok_dly == 0) begin data_sram_data_ok = 1; data_sram_rdata = rdata; post = 1; end
          else in_wait = 1;
        end
        rq++;
      end else if (in_wait) begin
        wc++;
        if (flush_wait && wc == 1) begin flush = 1; in_valid = 0; end
        if (wc == dok_dly) begin
          data_sram_data_ok = 1; data_sram_rdata = rdata; post = 1; in_wait = 0;
        end
      end
    end
    if (!fin) check("txn_timeout", 0, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_req", data_sram_req, 0);
    check("rst_ldv", ld_valid, 0);
    check("rst_ld_data", ld_data, 0);
    check("rst_wstrb", data_sram_wstrb, 0);
    check("rst_ale", ale, 0);

    // word store, addr_ok in first REQ cycle, data_ok two cycles later
    do_txn(0, 1, 2'd2, 0, 32'h1000, 32'hDEADBEEF, 32'h0, 0, 2, 0);
    check("sw_req_cyc", res_req, 1);
    check("sw_wstrb", res_strb, 4'b1111);
    check("sw_wdata", res_wd, 32'hDEADBEEF);
    check("sw_addr", res_addr, 32'h1000);
    check("sw_wr", res_wr, 1);
    check("sw_stall_cyc", res_stall, 4);
    check("sw_ldv", res_ldv, 0);

    // signed / unsigned byte load from lane 3
    do_txn(1, 0, 2'd0, 1, 32'h2003, 0, 32'h80123456, 0, 1, 0);
    check("lb_ldv", res_ldv, 1);
    check("lb_data", res_ld, 32'hFFFFFF80);
    check("lb_stall_cyc", res_stall, 3);
    check("lb_wstrb", res_strb, 4'b0000);
    do_txn(1, 0, 2'd0, 0, 32'h2003, 0, 32'h80123456, 0, 1, 0);
    check("lbu_ldv", res_ldv, 1);
    check("lbu_data", res_ld, 32'h00000080);

    // half store with addr_ok delayed 3 cycles
    do_txn(0, 1, 2'd1, 0, 32'h3002, 32'h0000ABCD, 32'h0, 3, 1, 0);
    check("sh_req_cyc", res_req, 4);
    check("sh_stable", res_unstable, 0);
    check("sh_wstrb", res_strb, 4'b1100);
    check("sh_wdata", res_wd, 32'hABCDABCD);
    check("sh_size", res_size, 1);
    check("sh_stall_cyc", res_stall, 6);

    // byte store lane 1, replicated data
    do_txn(0, 1, 2'd0, 0, 32'h1001, 32'h0000005A, 32'h0, 1, 1, 0);
    check("sb_wstrb", res_strb, 4'b0010);
    check("sb_wdata", res_wd, 32'h5A5A5A5A);
    check("sb_stall_cyc", res_stall, 4);

    // reserved size behaves as word
    do_txn(0, 1, 2'd3, 0, 32'h1004, 32'h01020304, 32'h0, 0, 1, 0);
    check("s3_wstrb", res_strb, 4'b1111);
    check("s3_size", res_size, 2);

    // zero-wait responses (addr_ok and data_ok together), half loads
    do_txn(1, 0, 2'd1, 1, 32'h2002, 0, 32'h80017FFF, 0, 0, 0);
    check("lh_zw_ldv", res_ldv, 1);
    check("lh_zw_data", res_ld, 32'hFFFF8001);
    check("lh_zw_stall", res_stall, 2);
    do_txn(1, 0, 2'd1, 1, 32'h2000, 0, 32'h80017FFF, 0, 0, 0);
    check("lh_lo_data", res_ld, 32'h00007FFF);

    // flushed word load drains without a result, then next load proceeds
    do_txn(1, 0, 2'd2, 0, 32'h2100, 0, 32'hCAFEF00D, 0, 2, 1);
    check("fl_ldv", res_ldv, 0);
    check("fl_stall_cyc", res_stall, 4);
    check("fl_ld_hold", ld_data, 32'h00007FFF);
    do_txn(1, 0, 2'd2, 0, 32'h2104, 0, 32'h12345678, 0, 1, 0);
    check("after_fl_req", res_req, 1);
    check("after_fl_data", res_ld, 32'h12345678);

`ifdef MM_ALE_CHECK_EN
    @(posedge clk); #1;
    in_valid = 1; in_re = 1; in_we = 0; in_size = 2'd2; in_addr = 32'h4002;
    @(negedge clk);
    check("ale_stall", stall, 0);
    check("ale_req0", data_sram_req, 0);
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    check("ale_pulse", ale, 1);
    check("ale_vaddr", ale_vaddr, 32'h4002);
    check("ale_req1", data_sram_req, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("ale_pulse_end", ale, 0);
`else
    do_txn(1, 0, 2'd2, 0, 32'h4002, 0, 32'h11223344, 0, 1, 0);
    check("mis_req", res_req, 1);
    check("mis_addr", res_addr, 32'h4002);
    check("mis_data", res_ld, 32'h11223344);
    check("mis_ale", res_ale, 0);
    check("mis_vaddr", ale_vaddr, 0);
`endif

    // reset during WAIT, then a stray data_ok
    @(posedge clk); #1;
    in_valid = 1; in_re = 1; in_we = 0; in_size = 2'd2; in_addr = 32'h5000;
    @(posedge clk); #1 data_sram_addr_ok = 1;
    @(posedge clk); #1;
    data_sram_addr_ok = 0; rst_n = 0; in_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1; data_sram_data_ok = 1; data_sram_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("rw_stall", stall, 0);
    check("rw_req", data_sram_req, 0);
    @(posedge clk); #1 data_sram_data_ok = 0;
    @(negedge clk);
    check("rw_ldv", ld_valid, 0);
    check("rw_ld_data", ld_data, 0);
    check("rw_stall2", stall, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mm_data_access.md
Name: mm_data_access

Overview:
- Memory-stage data access unit. Consumes the access request held in the EX→MM1 pipeline register: re/we, size, addr, wdata, sign.
- Drives the SRAM-like data bus (req/addr_ok/data_ok) to the data memory and returns aligned, extended load data to MM1/WB.
- Stalls the pipeline while a transaction is outstanding.
- Drains a flushed transaction without side effects to the pipeline.

Parameters:
- ADDR_W, 32, data bus address width; low 2 bits select the byte lane.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- in_valid  in  1  MM1 slot holds a valid instruction
- in_re  in  1  load request
- in_we  in  1  store request (in_re and in_we never both 1)
- in_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- in_sign  in  1  load sign-extend (1) / zero-extend (0)
- in_addr  in  ADDR_W  byte address
- in_wdata  in  32  store data, LSB-justified
- flush  in  1  kill current MM1 instruction
- stall  out  1  hold upstream pipeline
- ld_valid  out  1  one-cycle pulse: ld_data valid
- ld_data  out  32  extended load result
- ale  out  1  misaligned-access pulse (optional feature)
- ale_vaddr  out  ADDR_W  faulting address (optional feature)
- data_sram_req  out  1  bus request
- data_sram_wr  out  1  1=write
- data_sram_size  out  2  access size
- data_sram_wstrb  out  4  byte strobes
- data_sram_addr  out  ADDR_W  address
- data_sram_wdata  out  32  lane-replicated write data
- data_sram_addr_ok  in  1  request accepted
- data_sram_data_ok  in  1  response (read data / write ack)
- data_sram_rdata  in  32  read data

Behaviour:
- Reset and clock: rst_n, synchronous, active-low; clock clk.
- On reset: state=IDLE, all outputs and registered fields 0, cancel flag 0. Reset mid-transaction abandons it silently; the bench does not check the bus after reset.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - Accept when in_valid & (in_re|in_we) & !flush.
  - On accept, latch wr, size, addr, sign, strobes and replicated wdata; go to REQ.
  - stall=1 combinationally in the accept cycle.
- REQ:
  - data_sram_req=1; all bus fields come from registers and stay stable until addr_ok.
  - On addr_ok, go to WAIT.
  - A request once raised is never withdrawn, even on flush.
- WAIT:
  - req=0.
  - On data_ok: if a load and cancel=0, ld_valid=1 on the next cycle with registered ld_data. Go to IDLE.
  - addr_ok and data_ok in the same REQ cycle: treat as a zero-wait response, go directly to IDLE.
- stall: high from the accept cycle through the data_ok cycle inclusive. Low in the ld_valid cycle.
- Flush handling:
  - flush in REQ or WAIT sets cancel; cancel clears on return to IDLE.
  - A cancelled load produces no ld_valid.
  - A cancelled store still completes on the bus; it was already committed to issue.
  - stall stays high until drain completes, so no new request overlaps the old one.
- Write data and strobes:
  - byte: wstrb = 4'b0001 << addr[1:0], wdata = {4{b}}.
  - half: wstrb = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{h}}.
  - word: wstrb = 4'b1111, wdata unchanged.
  - Loads: wstrb=0.
- Load extraction uses latched addr[1:0]:
  - byte lane = rdata[8*addr[1:0]+:8].
  - half lane = addr[1] ? rdata[31:16] : rdata[15:0].
  - Then sign- or zero-extend to 32 bits.
- ld_data holds its value between pulses.

Optional Feature:
- Macro: MM_ALE_CHECK_EN.
- Defined:
  - In IDLE, an accepted access with half & addr[0], or word & addr[1:0]!=0, is not issued and the FSM stays in IDLE.
  - ale pulses 1 cycle after the accept cycle; ale_vaddr latches the address.
  - stall=0 for that instruction.
- Undefined: no check; ale and ale_vaddr tied 0; misaligned accesses are issued with the strobes given above.

Test Plan:
- Store word 0xDEADBEEF at 0x1000, addr_ok same cycle, data_ok 2 cycles later → req 1 cycle, wstrb=1111, wdata=0xDEADBEEF, stall high 4 cycles, no ld_valid.
- Signed byte load at 0x2003, rdata=0x80123456 → ld_data=0xFFFFFF80, one-cycle ld_valid. Repeat with in_sign=0 → 0x00000080.
- Half store 0xABCD at 0x3002, addr_ok delayed 3 cycles → req/addr/wstrb=1100/wdata=0xABCDABCD stable all 4 cycles, stall held.
- Word load, flush asserted in WAIT, data_ok 2 cycles later → no ld_valid, stall deasserts only after data_ok, next request issues after that.
- rst_n low during WAIT, then stray data_ok → outputs 0, state IDLE, no ld_valid.
- With MM_ALE_CHECK_EN: word load at 0x4002 → no req, ale pulse, ale_vaddr=0x4002, stall=0.
